// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment scan driver with a double-buffered frame.
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int unsigned DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] frame,
  input  logic [7:0]  blank,
`ifdef SEG7_BLINK_EN
  input  logic [7:0]  blink,
`endif
  output logic        ready,
  output logic [7:0]  an,
  output logic [6:0]  digit,
  output logic [2:0]  scan_idx
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          wrap;
  logic          boundary;

  logic          pend_valid;
  logic [31:0]   pend_frame;
  logic [7:0]    pend_blank;
  logic [31:0]   act_frame;
  logic [7:0]    act_blank;

  logic          accept;
  logic          xfer;

  logic [3:0]    code;
  logic          off;
  logic [7:0]    an_next;
  logic [6:0]    digit_next;

`ifdef SEG7_BLINK_EN
  logic [7:0]    pend_blink;
  logic [7:0]    act_blink;
  logic [5:0]    frame_cnt;
`endif

  assign wrap     = (presc == PMAX);
  assign boundary = wrap && (scan_idx == 3'd7);
  assign ready    = ~pend_valid;
  assign accept   = load && ready;
  assign xfer     = boundary && pend_valid;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc    <= '0;
      scan_idx <= 3'd0;
    end else if (wrap) begin
      presc    <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      presc    <= presc + PW'(1);
    end
  end

  // An accept needs an empty pending slot and a transfer needs a full one,
  // so the two never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      act_frame  <= 32'd0;
      act_blank  <= 8'hFF;
    end else begin
      if (xfer) begin
        pend_valid <= 1'b0;
        act_frame  <= pend_frame;
        act_blank  <= pend_blank;
      end
      if (accept) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // NOTE: pending data is not reset; pend_valid alone decides whether it is
  // ever used, so the payload needs no reset network.
  always_ff @(posedge clock) begin
    if (accept) begin
      pend_frame <= frame;
      pend_blank <= blank;
    end
  end

`ifdef SEG7_BLINK_EN
  always_ff @(posedge clock) begin
    if (accept) begin
      pend_blink <= blink;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      act_blink <= 8'd0;
      frame_cnt <= 6'd0;
    end else begin
      if (xfer) begin
        act_blink <= pend_blink;
      end
      if (boundary) begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    code       = act_frame[{scan_idx, 2'b00} +: 4];
    off        = act_blank[scan_idx];
`ifdef SEG7_BLINK_EN
    off        = off | (act_blink[scan_idx] & frame_cnt[5]);
`endif
    an_next    = 8'hFF;
    digit_next = 7'h7F;
    if (!off) begin
      an_next    = ~(8'd1 << scan_idx);
      digit_next = glyph(code);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an    <= 8'hFF;
      digit <= 7'h7F;
    end else begin
      an    <= an_next;
      digit <= digit_next;
    end
  end

endmodule
